// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single-outstanding core memory requests into APB
// SETUP/ACCESS transfers and returns one registered response per request.
// Optional watchdog: define APB_BRIDGE_TIMEOUT_EN to force an error response
// after TIMEOUT_CYCLES ACCESS cycles without pready.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_next;
  logic   accept;
  logic   complete;
  logic   expire;

  // A watchdog limit of zero would never let a transfer reach ACCESS safely.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] access_cnt;

  // Count ACCESS cycles spent waiting on the slave; restart for every new transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      access_cnt <= '0;
    end else if (accept) begin
      access_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      access_cnt <= access_cnt + 1'b1;
    end
  end

  // The limit is hit on the waiting cycle that brings the count to TIMEOUT_CYCLES;
  // pready in that same cycle still completes the transfer normally.
  assign expire = (state == ACCESS) && !pready &&
                  (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // State register; reset abandons any transfer in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the APB/handshake controls decoded from the current state.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (expire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request into the APB address/data registers; they hold between transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pwstrb <= '0;
    end else if (accept) begin
      paddr  <= req_addr;
      pwrite <= req_write;
      pwdata <= req_wdata;
      pwstrb <= req_write ? req_wstrb : 4'b0000;
    end
  end

  // Register the response: one-cycle valid pulse, data/error held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete | expire;
      if (complete) begin
        rsp_err   <= pslverr;
        rsp_rdata <= pwrite ? 32'h0 : prdata;
      end else if (expire) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed plus randomized transfers against a word
// memory slave, checked by a transaction-level reference model.
// Timeout scenarios run only when APB_BRIDGE_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  localparam int TO = 4;
`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] modelMem [0:255];
  logic [31:0] lastData;

  logic [31:0] slaveMem [0:255];
  int          slaveWaits = 0;
  bit          slaveErr   = 1'b0;
  int          accessCnt;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pwstrb    (pwstrb),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave answers after slaveWaits wait states with optional error; reads return its memory.
  assign pready  = psel && penable && (accessCnt == slaveWaits);
  assign pslverr = pready && slaveErr;
  assign prdata  = slaveMem[paddr[9:2]];

  // Slave state: wait-state counter and byte-strobed memory written on error-free completion.
  always @(posedge clk) begin
    if (rst) begin
      accessCnt <= 0;
      for (int i = 0; i < 256; i++) slaveMem[i] <= 32'h0;
    end else begin
      if (psel && penable && !pready) accessCnt <= accessCnt + 1;
      else accessCnt <= 0;
      if (pready && pwrite && !slaveErr) begin
        for (int b = 0; b < 4; b++) begin
          if (pwstrb[b]) slaveMem[paddr[9:2]][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  // Run one transfer starting just after a negedge; returns at the negedge of its response cycle.
  task automatic applyStimulus(input logic [31:0] addr, input bit write, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int waits, input bit err,
                               input bit noise);
    int          expLat;
    int          k;
    bit          timedOut;
    bit          seen;
    bit          expErr;
    logic [31:0] expData;
    logic [3:0]  expStrb;
    timedOut = TIMEOUT_ON && (waits >= TO);
    expLat   = timedOut ? (2 + TO) : (3 + waits);
    expErr   = timedOut ? 1'b1 : err;
    expData  = (write || timedOut) ? 32'h0 : modelMem[addr[9:2]];
    expStrb  = write ? wstrb : 4'b0000;
    if (write && !expErr) modelMem[addr[9:2]] = mergeBytes(modelMem[addr[9:2]], wdata, wstrb);

    slaveWaits = waits;
    slaveErr   = err;
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = write;
    req_wdata = wdata;
    req_wstrb = wstrb;

    @(negedge clk);
    k = 1;
    checkOutput("setup_psel", psel, 1);
    checkOutput("setup_penable", penable, 0);
    checkOutput("setup_paddr", paddr, addr);
    checkOutput("setup_pwrite", pwrite, write);
    checkOutput("setup_pwdata", pwdata, wdata);
    checkOutput("setup_pwstrb", pwstrb, expStrb);
    checkOutput("setup_req_ready", req_ready, 0);
    checkOutput("rsp_single_pulse", rsp_valid, 0);
    checkOutput("rsp_rdata_hold", rsp_rdata, lastData);
    req_valid = noise;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));

    seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        checkOutput("access_psel", psel, 1);
        checkOutput("access_penable", penable, 1);
        checkOutput("access_paddr", paddr, addr);
        checkOutput("access_pwstrb", pwstrb, expStrb);
        checkOutput("access_req_ready", req_ready, 0);
      end
      if (k >= expLat) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checkOutput("rsp_latency", k, expLat);
    checkOutput("rsp_err", rsp_err, expErr);
    checkOutput("rsp_rdata", rsp_rdata, expData);
    checkOutput("rsp_req_ready", req_ready, 1);
    checkOutput("rsp_psel", psel, 0);
    checkOutput("rsp_penable", penable, 0);
    lastData = expData;
  endtask

  // Idle cycles between transfers: the response pulse must be gone and its data held.
  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("gap_rsp_valid", rsp_valid, 0);
      checkOutput("gap_rsp_rdata", rsp_rdata, lastData);
      checkOutput("gap_psel", psel, 0);
    end
  endtask

  // Directed scenarios first, then randomized traffic; ends with the summary line.
  initial begin
    logic [31:0] rAddr;
    logic [31:0] rData;
    int          rWaits;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_write = 1'b0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    lastData  = 32'h0;
    for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("reset_psel", psel, 0);
    checkOutput("reset_penable", penable, 0);
    checkOutput("reset_paddr", paddr, 0);
    checkOutput("reset_pwrite", pwrite, 0);
    checkOutput("reset_pwdata", pwdata, 0);
    checkOutput("reset_pwstrb", pwstrb, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_req_ready", req_ready, 1);
    rst = 1'b0;
    idleGap(1);

    $display("[TB] write then read, zero-wait slave");
    applyStimulus(32'h100, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0);
    applyStimulus(32'h100, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
    checkOutput("directed_rd_deadbeef", rsp_rdata, 32'hDEADBEEF);
    idleGap(2);

    $display("[TB] partial write");
    applyStimulus(32'h104, 1'b1, 32'h11223344, 4'hF, 0, 1'b0, 1'b0);
    applyStimulus(32'h104, 1'b1, 32'h000000AA, 4'b0001, 0, 1'b0, 1'b1);
    applyStimulus(32'h104, 1'b0, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b0);
    checkOutput("directed_rd_partial", rsp_rdata, 32'h112233AA);
    idleGap(1);

    $display("[TB] wait states and slave error");
    applyStimulus(32'h100, 1'b0, 32'h0, 4'h0, 3, 1'b0, 1'b1);
    applyStimulus(32'h108, 1'b1, 32'hCAFEF00D, 4'hF, 1, 1'b1, 1'b0);
    applyStimulus(32'h108, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    applyStimulus(32'h104, 1'b0, 32'h0, 4'h0, 2, 1'b1, 1'b0);
    idleGap(1);

    $display("[TB] reset mid-transfer");
    slaveWaits = 10;
    slaveErr   = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h200;
    req_write  = 1'b1;
    req_wdata  = 32'h55AA55AA;
    req_wstrb  = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_access", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_psel", psel, 0);
    checkOutput("abort_penable", penable, 0);
    checkOutput("abort_req_ready", req_ready, 1);
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;
    lastData = 32'h0;
    idleGap(3);
    applyStimulus(32'h200, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);

`ifdef APB_BRIDGE_TIMEOUT_EN
    $display("[TB] timeout and pready-on-limit");
    applyStimulus(32'h300, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 1'b0);
    checkOutput("timeout_err", rsp_err, 1);
    idleGap(1);
    applyStimulus(32'h304, 1'b1, 32'h12345678, 4'hF, 1000, 1'b0, 1'b0);
    applyStimulus(32'h304, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 1'b0);
    checkOutput("limit_pready_wins_err", rsp_err, 0);
    idleGap(1);
`endif

    $display("[TB] randomized traffic");
    for (int n = 0; n < 30; n++) begin
      rAddr  = 32'($urandom_range(0, 1023));
      rData  = $urandom;
      rWaits = TIMEOUT_ON ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 4));
      applyStimulus(rAddr, 1'($urandom_range(0, 1)), rData, 4'($urandom_range(0, 15)), rWaits,
                    ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      idleGap(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
